mem_stage_hs: RTL and testbench

Parametrised memory-access pipeline stage sitting between EX and WB. It replaces the fixed single-cycle MEM register with a valid/ready handshake on both sides and a request/response data-memory port tolerating any number of wait states. It performs byte-lane steering, sign/zero extension and store strobe generation from the low address bits, and detects misaligned accesses. It also drives a forwarding bus with an outstanding-load indicator for the ID stage.

---
 rtl/mem_stage_hs_if.sv | 68 ++++++
 rtl/mem_stage_hs.sv | 272 +++++++++++++++++++++++++++
 tb/tb_mem_stage_hs.sv | 369 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_hs_if.sv
// -----------------------------------------------------------------------------
// mem_stage_hs_if
// Purpose : Groups every handshake and bus signal of the MEM pipeline stage:
//           the EX->MEM valid/ready handshake, the data-memory request/response
//           port, the MEM->WB handshake and the forwarding bus toward ID.
// Modports:
//   slave  - the stage itself (consumes ex_*, dm responses and wb_ready)
//   master - the surrounding pipeline / memory / WB environment
// Parameters: DW data width (32/64), AW byte-address width, PC_W PC width,
//             RW register-file address width.
// -----------------------------------------------------------------------------
interface mem_stage_hs_if #(
   parameter int DW   = 32,
   parameter int AW   = 32,
   parameter int PC_W = 32,
   parameter int RW   = 5
);
   // pipeline control
   logic            flush;
   // EX -> MEM
   logic            ex_valid;
   logic            ex_ready;
   logic [PC_W-1:0] ex_pc;
   logic            ex_rf_we;
   logic [RW-1:0]   ex_rf_waddr;
   logic [DW-1:0]   ex_result;
   logic [3:0]      ex_op;
   logic [DW-1:0]   ex_store_data;
   // data memory port
   logic            dm_req;
   logic            dm_wr;
   logic [AW-1:0]   dm_addr;
   logic [DW/8-1:0] dm_wstrb;
   logic [DW-1:0]   dm_wdata;
   logic            dm_addr_ok;
   logic            dm_data_ok;
   logic [DW-1:0]   dm_rdata;
   // MEM -> WB
   logic            wb_valid;
   logic            wb_ready;
   logic [PC_W-1:0] wb_pc;
   logic            wb_rf_we;
   logic [RW-1:0]   wb_rf_waddr;
   logic [DW-1:0]   wb_rf_wdata;
   logic            wb_excp;
   logic [AW-1:0]   wb_badaddr;
   // forwarding toward ID
   logic            fwd_valid;
   logic [RW-1:0]   fwd_waddr;
   logic [DW-1:0]   fwd_wdata;
   logic            fwd_pending;

   modport slave (
      input  flush, ex_valid, ex_pc, ex_rf_we, ex_rf_waddr, ex_result, ex_op,
             ex_store_data, dm_addr_ok, dm_data_ok, dm_rdata, wb_ready,
      output ex_ready, dm_req, dm_wr, dm_addr, dm_wstrb, dm_wdata, wb_valid,
             wb_pc, wb_rf_we, wb_rf_waddr, wb_rf_wdata, wb_excp, wb_badaddr,
             fwd_valid, fwd_waddr, fwd_wdata, fwd_pending
   );

   modport master (
      output flush, ex_valid, ex_pc, ex_rf_we, ex_rf_waddr, ex_result, ex_op,
             ex_store_data, dm_addr_ok, dm_data_ok, dm_rdata, wb_ready,
      input  ex_ready, dm_req, dm_wr, dm_addr, dm_wstrb, dm_wdata, wb_valid,
             wb_pc, wb_rf_we, wb_rf_waddr, wb_rf_wdata, wb_excp, wb_badaddr,
             fwd_valid, fwd_waddr, fwd_wdata, fwd_pending
   );
endinterface

// File: rtl/mem_stage_hs.sv
// -----------------------------------------------------------------------------
// mem_stage_hs
// Purpose : Memory-access pipeline stage between EX and WB with valid/ready
//           handshakes on both sides and a request/response data-memory port
//           that tolerates any number of wait states. Performs load byte-lane
//           extraction with sign/zero extension, store data replication and
//           strobe generation, misaligned-access detection, and drives a
//           forwarding bus with an outstanding-load indicator.
// Ports   :
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset (memory side must be reset with it)
//   bus  - mem_stage_hs_if.slave: flush, ex_*, dm_*, wb_*, fwd_* signals
// Parameters: DW (32 or 64), AW, PC_W, RW must match the interface instance.
// -----------------------------------------------------------------------------
module mem_stage_hs #(
   parameter int DW   = 32,
   parameter int AW   = 32,
   parameter int PC_W = 32,
   parameter int RW   = 5
) (
   input  logic          clk,
   input  logic          rst,
   mem_stage_hs_if.slave bus
);
   localparam int SW = DW / 8;        // bytes per memory word
   localparam int LB = $clog2(SW);    // byte-lane index width

   typedef enum logic [2:0] {
      S_EMPTY  = 3'd0,
      S_REQ    = 3'd1,
      S_RESP   = 3'd2,
      S_FULL   = 3'd3,
      S_CANCEL = 3'd4
   } state_t;

   // sz: 0 byte, 1 half, 2 word, 3 double
   typedef struct packed {
      logic       mem;
      logic       load;
      logic       store;
      logic       sext;
      logic [1:0] sz;
   } dec_t;

   // Opcode decode; 64-bit-only ops collapse to "none" on a 32-bit datapath.
   function automatic dec_t decode_op(input logic [3:0] op);
      dec_t d;
      d = '0;
      case (op)
         4'd1:    begin d.load  = 1'b1; d.sext = 1'b1; d.sz = 2'd0; end
         4'd2:    begin d.load  = 1'b1; d.sz   = 2'd0; end
         4'd3:    begin d.load  = 1'b1; d.sext = 1'b1; d.sz = 2'd1; end
         4'd4:    begin d.load  = 1'b1; d.sz   = 2'd1; end
         4'd5:    begin d.load  = 1'b1; d.sext = 1'b1; d.sz = 2'd2; end
         4'd6:    begin d.load  = 1'b1; d.sz   = 2'd2; end
         4'd7:    begin d.load  = 1'b1; d.sz   = 2'd3; end
         4'd8:    begin d.store = 1'b1; d.sz   = 2'd0; end
         4'd9:    begin d.store = 1'b1; d.sz   = 2'd1; end
         4'd10:   begin d.store = 1'b1; d.sz   = 2'd2; end
         4'd11:   begin d.store = 1'b1; d.sz   = 2'd3; end
         default: d = '0;
      endcase
      if ((DW == 32) && ((op == 4'd6) || (op == 4'd7) || (op == 4'd11))) begin
         d = '0;
      end else begin
         d.mem = d.load | d.store;
      end
      return d;
   endfunction

   // An access is misaligned when any address bit below its size is set.
   function automatic logic misaligned(input logic [1:0] sz, input logic [2:0] a);
      logic m;
      case (sz)
         2'd1:    m = a[0];
         2'd2:    m = |a[1:0];
         2'd3:    m = |a[2:0];
         default: m = 1'b0;
      endcase
      return m;
   endfunction

   // Store data is replicated across the word so any lane sees the operand.
   function automatic logic [DW-1:0] store_rep(input logic [1:0] sz, input logic [DW-1:0] d);
      logic [DW-1:0] r;
      case (sz)
         2'd0:    r = {SW{d[7:0]}};
         2'd1:    r = {(SW/2){d[15:0]}};
         2'd2:    r = {(SW/4){d[31:0]}};
         default: r = d;
      endcase
      return r;
   endfunction

   // Byte-enable mask of the access size, shifted to its lane.
   function automatic logic [SW-1:0] store_strb(input logic [1:0] sz, input logic [LB-1:0] lane);
      logic [SW-1:0] m;
      case (sz)
         2'd0:    m = SW'(8'h01);
         2'd1:    m = SW'(8'h03);
         2'd2:    m = SW'(8'h0F);
         default: m = SW'(8'hFF);
      endcase
      return m << lane;
   endfunction

   // Right-align the addressed lane, then sign/zero extend to DW. A word on a
   // 32-bit datapath has no bits above it, so its extension term is zero.
   function automatic logic [DW-1:0] load_ext(input logic [DW-1:0] rd, input logic [LB-1:0] lane,
                                              input logic [1:0] sz, input logic sext);
      logic [DW-1:0] sh;
      logic [DW-1:0] r;
      sh = rd >> {lane, 3'b000};
      case (sz)
         2'd0:    r = DW'(sh[7:0])  | ((sext && sh[7])  ? ~DW'(8'hFF)         : '0);
         2'd1:    r = DW'(sh[15:0]) | ((sext && sh[15]) ? ~DW'(16'hFFFF)      : '0);
         2'd2:    r = DW'(sh[31:0]) | ((sext && sh[31]) ? ~DW'(32'hFFFF_FFFF) : '0);
         default: r = sh;
      endcase
      return r;
   endfunction

   state_t          state_r;
   state_t          state_nxt_s;
   logic            ex_ready_s;
   logic            accept_s;
   logic            load_done_s;
   dec_t            dec_in_s;
   logic            mis_in_s;
   logic [AW-1:0]   addr_in_s;
   state_t          accept_tgt_s;

   logic [PC_W-1:0] pc_r;
   logic            rf_we_r;
   logic [RW-1:0]   waddr_r;
   logic [AW-1:0]   addr_r;
   logic            load_r;
   logic            store_r;
   logic            sext_r;
   logic [1:0]      sz_r;
   logic [DW-1:0]   result_r;
   logic            excp_r;
   logic [AW-1:0]   badaddr_r;
   logic [DW-1:0]   wdata_r;
   logic [SW-1:0]   wstrb_r;

   // Decode the instruction offered by EX and pick its first state.
   always_comb begin
      addr_in_s    = AW'(bus.ex_result);
      dec_in_s     = decode_op(bus.ex_op);
      mis_in_s     = dec_in_s.mem && misaligned(dec_in_s.sz, addr_in_s[2:0]);
      accept_tgt_s = S_FULL;
      if (dec_in_s.mem && !mis_in_s) begin
         accept_tgt_s = S_REQ;
      end else begin
         accept_tgt_s = S_FULL;
      end
   end

   // EX-side readiness: free slot, or a result leaving to WB this cycle.
   always_comb begin
      ex_ready_s = 1'b0;
      if (!bus.flush && ((state_r == S_EMPTY) || ((state_r == S_FULL) && bus.wb_ready))) begin
         ex_ready_s = 1'b1;
      end else begin
         ex_ready_s = 1'b0;
      end
   end

   assign accept_s = bus.ex_valid && ex_ready_s;

   // Next-state logic. A request already accepted by memory cannot be
   // withdrawn, so a flush then parks in CANCEL to drain its response.
   always_comb begin
      state_nxt_s = state_r;
      load_done_s = 1'b0;
      case (state_r)
         S_EMPTY: begin
            if (accept_s) state_nxt_s = accept_tgt_s;
            else          state_nxt_s = S_EMPTY;
         end
         S_REQ: begin
            if (bus.flush)           state_nxt_s = bus.dm_addr_ok ? S_CANCEL : S_EMPTY;
            else if (bus.dm_addr_ok) state_nxt_s = S_RESP;
            else                     state_nxt_s = S_REQ;
         end
         S_RESP: begin
            if (bus.dm_data_ok) begin
               state_nxt_s = bus.flush ? S_EMPTY : S_FULL;
               load_done_s = !bus.flush;
            end else if (bus.flush) begin
               state_nxt_s = S_CANCEL;
            end else begin
               state_nxt_s = S_RESP;
            end
         end
         S_FULL: begin
            if (bus.flush)         state_nxt_s = S_EMPTY;
            else if (accept_s)     state_nxt_s = accept_tgt_s;
            else if (bus.wb_ready) state_nxt_s = S_EMPTY;
            else                   state_nxt_s = S_FULL;
         end
         S_CANCEL: begin
            if (bus.dm_data_ok) state_nxt_s = S_EMPTY;
            else                state_nxt_s = S_CANCEL;
         end
         default: state_nxt_s = S_EMPTY;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_r <= S_EMPTY;
      else      state_r <= state_nxt_s;
   end

   // Instruction holding registers; loaded on accept, load data on response.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_r      <= '0;
         rf_we_r   <= 1'b0;
         waddr_r   <= '0;
         addr_r    <= '0;
         load_r    <= 1'b0;
         store_r   <= 1'b0;
         sext_r    <= 1'b0;
         sz_r      <= 2'd0;
         result_r  <= '0;
         excp_r    <= 1'b0;
         badaddr_r <= '0;
         wdata_r   <= '0;
         wstrb_r   <= '0;
      end else if (accept_s) begin
         pc_r      <= bus.ex_pc;
         waddr_r   <= bus.ex_rf_waddr;
         addr_r    <= addr_in_s;
         // a faulting access never touches memory nor the register file
         rf_we_r   <= bus.ex_rf_we && !dec_in_s.store && !mis_in_s;
         load_r    <= dec_in_s.load && !mis_in_s;
         store_r   <= dec_in_s.store && !mis_in_s;
         sext_r    <= dec_in_s.sext;
         sz_r      <= dec_in_s.sz;
         result_r  <= dec_in_s.mem ? '0 : bus.ex_result;
         excp_r    <= mis_in_s;
         badaddr_r <= mis_in_s ? addr_in_s : '0;
         wdata_r   <= dec_in_s.store ? store_rep(dec_in_s.sz, bus.ex_store_data) : '0;
         wstrb_r   <= dec_in_s.store ? store_strb(dec_in_s.sz, addr_in_s[LB-1:0]) : '0;
      end else if (load_done_s && load_r) begin
         result_r  <= load_ext(bus.dm_rdata, addr_r[LB-1:0], sz_r, sext_r);
      end
   end

   assign bus.ex_ready    = ex_ready_s;
   assign bus.dm_req      = (state_r == S_REQ);
   assign bus.dm_wr       = store_r;
   assign bus.dm_addr     = addr_r;
   assign bus.dm_wstrb    = wstrb_r;
   assign bus.dm_wdata    = wdata_r;
   assign bus.wb_valid    = (state_r == S_FULL);
   assign bus.wb_pc       = pc_r;
   assign bus.wb_rf_we    = rf_we_r;
   assign bus.wb_rf_waddr = waddr_r;
   assign bus.wb_rf_wdata = result_r;
   assign bus.wb_excp     = excp_r;
   assign bus.wb_badaddr  = badaddr_r;
   assign bus.fwd_valid   = (state_r == S_FULL) && rf_we_r;
   assign bus.fwd_waddr   = waddr_r;
   assign bus.fwd_wdata   = result_r;
   // ID must stall on a matching source while this load is still in memory
   assign bus.fwd_pending = ((state_r == S_REQ) || (state_r == S_RESP)) && load_r && rf_we_r;

endmodule

// File: tb/tb_mem_stage_hs.sv
// -----------------------------------------------------------------------------
// tb_mem_stage_hs
// Purpose : Directed plus randomized check of mem_stage_hs. A DW=32 and a
//           DW=64 instance share one stimulus set; "sel" routes ex_valid to one
//           of them and selects whose outputs are observed. Expected values
//           come from an arithmetic model of the access rules.
// -----------------------------------------------------------------------------
module tb_mem_stage_hs;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        sel;
   logic        flush, ex_valid, ex_rf_we, dm_addr_ok, dm_data_ok, wb_ready;
   logic [31:0] ex_pc;
   logic [4:0]  ex_rf_waddr;
   logic [3:0]  ex_op;
   logic [63:0] ex_result, ex_store_data, dm_rdata;
   int          n_cmp = 0;
   int          n_err = 0;

   mem_stage_hs_if #(.DW(32), .AW(32), .PC_W(32), .RW(5)) i32 ();
   mem_stage_hs_if #(.DW(64), .AW(32), .PC_W(32), .RW(5)) i64 ();

   mem_stage_hs #(.DW(32), .AW(32), .PC_W(32), .RW(5)) dut32 (.clk(clk), .rst(rst), .bus(i32));
   mem_stage_hs #(.DW(64), .AW(32), .PC_W(32), .RW(5)) dut64 (.clk(clk), .rst(rst), .bus(i64));

   assign i32.flush         = flush;
   assign i32.ex_valid      = ex_valid & ~sel;
   assign i32.ex_pc         = ex_pc;
   assign i32.ex_rf_we      = ex_rf_we;
   assign i32.ex_rf_waddr   = ex_rf_waddr;
   assign i32.ex_result     = ex_result[31:0];
   assign i32.ex_op         = ex_op;
   assign i32.ex_store_data = ex_store_data[31:0];
   assign i32.dm_addr_ok    = dm_addr_ok;
   assign i32.dm_data_ok    = dm_data_ok;
   assign i32.dm_rdata      = dm_rdata[31:0];
   assign i32.wb_ready      = wb_ready;

   assign i64.flush         = flush;
   assign i64.ex_valid      = ex_valid & sel;
   assign i64.ex_pc         = ex_pc;
   assign i64.ex_rf_we      = ex_rf_we;
   assign i64.ex_rf_waddr   = ex_rf_waddr;
   assign i64.ex_result     = ex_result;
   assign i64.ex_op         = ex_op;
   assign i64.ex_store_data = ex_store_data;
   assign i64.dm_addr_ok    = dm_addr_ok;
   assign i64.dm_data_ok    = dm_data_ok;
   assign i64.dm_rdata      = dm_rdata;
   assign i64.wb_ready      = wb_ready;

   logic [63:0] o_ex_ready, o_dm_req, o_dm_wr, o_dm_addr, o_dm_wstrb, o_dm_wdata;
   logic [63:0] o_wb_valid, o_wb_pc, o_wb_we, o_wb_waddr, o_wb_wdata, o_excp, o_badaddr;
   logic [63:0] o_fwd_valid, o_fwd_waddr, o_fwd_wdata, o_fwd_pending;

   assign o_ex_ready    = 64'(sel ? i64.ex_ready    : i32.ex_ready);
   assign o_dm_req      = 64'(sel ? i64.dm_req      : i32.dm_req);
   assign o_dm_wr       = 64'(sel ? i64.dm_wr       : i32.dm_wr);
   assign o_dm_addr     = 64'(sel ? i64.dm_addr     : i32.dm_addr);
   assign o_dm_wstrb    = sel ? 64'(i64.dm_wstrb) : 64'(i32.dm_wstrb);
   assign o_dm_wdata    = sel ? i64.dm_wdata : 64'(i32.dm_wdata);
   assign o_wb_valid    = 64'(sel ? i64.wb_valid    : i32.wb_valid);
   assign o_wb_pc       = 64'(sel ? i64.wb_pc       : i32.wb_pc);
   assign o_wb_we       = 64'(sel ? i64.wb_rf_we    : i32.wb_rf_we);
   assign o_wb_waddr    = 64'(sel ? i64.wb_rf_waddr : i32.wb_rf_waddr);
   assign o_wb_wdata    = sel ? i64.wb_rf_wdata : 64'(i32.wb_rf_wdata);
   assign o_excp        = 64'(sel ? i64.wb_excp     : i32.wb_excp);
   assign o_badaddr     = 64'(sel ? i64.wb_badaddr  : i32.wb_badaddr);
   assign o_fwd_valid   = 64'(sel ? i64.fwd_valid   : i32.fwd_valid);
   assign o_fwd_waddr   = 64'(sel ? i64.fwd_waddr   : i32.fwd_waddr);
   assign o_fwd_wdata   = sel ? i64.fwd_wdata : 64'(i32.fwd_wdata);
   assign o_fwd_pending = 64'(sel ? i64.fwd_pending : i32.fwd_pending);

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // advance to just after the next rising edge
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // access table: size in bytes (0 = not a memory op), load/store, signed
   function automatic void decode(input logic [3:0] op, input int dwv, output int sz,
                                  output bit ld, output bit st, output bit sx);
      sz = 0; ld = 1'b0; st = 1'b0; sx = 1'b0;
      case (op)
         4'd1:  begin sz = 1; ld = 1'b1; sx = 1'b1; end
         4'd2:  begin sz = 1; ld = 1'b1; end
         4'd3:  begin sz = 2; ld = 1'b1; sx = 1'b1; end
         4'd4:  begin sz = 2; ld = 1'b1; end
         4'd5:  begin sz = 4; ld = 1'b1; sx = 1'b1; end
         4'd6:  if (dwv == 64) begin sz = 4; ld = 1'b1; end
         4'd7:  if (dwv == 64) begin sz = 8; ld = 1'b1; end
         4'd8:  begin sz = 1; st = 1'b1; end
         4'd9:  begin sz = 2; st = 1'b1; end
         4'd10: begin sz = 4; st = 1'b1; end
         4'd11: if (dwv == 64) begin sz = 8; st = 1'b1; end
         default: sz = 0;
      endcase
   endfunction

   // loaded value: pick sz bytes at the lane offset, extend as two's complement
   function automatic logic [63:0] load_model(input logic [63:0] rd, input logic [63:0] a,
                                              input int sz, input bit sx, input int dwv);
      logic [63:0] lane, v, lim;
      lane = a % 64'(dwv / 8);
      v    = rd >> (8 * lane);
      if (sz != 8) begin
         lim = 64'd1 << (8 * sz);
         v   = v % lim;
         if (sx && (v >= lim / 2)) v = v - lim;
      end
      if (dwv == 32) v = v & 64'hFFFF_FFFF;
      return v;
   endfunction

   // one instruction end to end: accept, memory phases with the given wait
   // counts, then wb_ready withheld for 'stall' cycles
   task automatic run_one(input bit s, input logic [3:0] op, input logic [63:0] addr,
                          input logic [63:0] sd, input bit rfwe, input logic [4:0] wa,
                          input logic [31:0] pc, input logic [63:0] rd,
                          input int aw, input int dwt, input int stall);
      int dwv, sz;
      bit ld, st, sx, mis, exp_we;
      logic [63:0] dmask, a, val, exp_wd, exp_strb, exp_res;
      dwv   = s ? 64 : 32;
      dmask = s ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF;
      decode(op, dwv, sz, ld, st, sx);
      a      = addr & 64'hFFFF_FFFF;
      mis    = (sz != 0) && ((a % 64'(sz)) != 64'd0);
      exp_we = rfwe && !st && !mis;
      sel = s; ex_valid = 1'b1; ex_op = op; ex_result = addr; ex_store_data = sd;
      ex_rf_we = rfwe; ex_rf_waddr = wa; ex_pc = pc;
      wb_ready = 1'b1; dm_addr_ok = 1'b0; dm_data_ok = 1'b0; flush = 1'b0;
      #1;
      chk("accept_ready", o_ex_ready, 64'd1);
      cyc();
      ex_valid = 1'b0;
      if ((sz != 0) && !mis) begin
         val = (sz == 8) ? sd : (sd % (64'd1 << (8 * sz)));
         exp_wd = 64'd0;
         for (int k = 0; k < dwv / (8 * sz); k++) exp_wd = exp_wd | (val << (8 * sz * k));
         exp_strb = ((64'd1 << sz) - 64'd1) << (a % 64'(dwv / 8));
         for (int i = 0; i <= aw; i++) begin
            dm_addr_ok = (i == aw);
            #1;
            chk("req_dm_req", o_dm_req, 64'd1);
            chk("req_dm_addr", o_dm_addr, a);
            chk("req_dm_wr", o_dm_wr, 64'(st));
            if (st) begin
               chk("req_wstrb", o_dm_wstrb, exp_strb);
               chk("req_wdata", o_dm_wdata, exp_wd & dmask);
            end
            chk("req_pending", o_fwd_pending, 64'(ld && rfwe));
            chk("req_ex_ready", o_ex_ready, 64'd0);
            chk("req_wb_valid", o_wb_valid, 64'd0);
            cyc();
         end
         dm_addr_ok = 1'b0;
         for (int i = 0; i <= dwt; i++) begin
            dm_data_ok = (i == dwt);
            dm_rdata   = rd;
            #1;
            chk("resp_dm_req", o_dm_req, 64'd0);
            chk("resp_pending", o_fwd_pending, 64'(ld && rfwe));
            chk("resp_wb_valid", o_wb_valid, 64'd0);
            cyc();
         end
         dm_data_ok = 1'b0;
      end
      if (sz == 0) exp_res = addr & dmask;
      else         exp_res = load_model(rd & dmask, a, sz, sx, dwv);
      for (int i = 0; i <= stall; i++) begin
         wb_ready = (i == stall);
         #1;
         chk("wb_valid", o_wb_valid, 64'd1);
         chk("wb_pc", o_wb_pc, 64'(pc));
         chk("wb_rf_we", o_wb_we, 64'(exp_we));
         chk("wb_waddr", o_wb_waddr, 64'(wa));
         chk("wb_excp", o_excp, 64'(mis));
         if (mis) chk("wb_badaddr", o_badaddr, a);
         if (mis) chk("mis_no_req", o_dm_req, 64'd0);
         if ((sz == 0) || exp_we) begin
            chk("wb_wdata", o_wb_wdata, exp_res);
            chk("fwd_wdata", o_fwd_wdata, exp_res);
         end
         chk("fwd_valid", o_fwd_valid, 64'(exp_we));
         chk("fwd_waddr", o_fwd_waddr, 64'(wa));
         chk("full_ex_ready", o_ex_ready, 64'(i == stall));
         cyc();
      end
      #1;
      chk("drained", o_wb_valid, 64'd0);
   endtask

   // start a load at 0x100 on the DW=32 instance; returns in REQ
   task automatic start_lw();
      sel = 1'b0; ex_valid = 1'b1; ex_op = 4'd5; ex_result = 64'h100; ex_rf_we = 1'b1;
      ex_rf_waddr = 5'd7; wb_ready = 1'b1;
      #1;
      cyc();
      ex_valid = 1'b0;
   endtask

   initial begin
      logic [63:0] vals [3];
      rst = 1'b0; sel = 1'b0; flush = 1'b0; ex_valid = 1'b0; ex_rf_we = 1'b0;
      dm_addr_ok = 1'b0; dm_data_ok = 1'b0; wb_ready = 1'b0;
      ex_pc = 32'd0; ex_rf_waddr = 5'd0; ex_op = 4'd0;
      ex_result = 64'd0; ex_store_data = 64'd0; dm_rdata = 64'd0;
      repeat (2) cyc();

      // reset state on both widths
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         #1;
         chk("rst_ex_ready", o_ex_ready, 64'd1);
         chk("rst_dm_req", o_dm_req, 64'd0);
         chk("rst_dm_wstrb", o_dm_wstrb, 64'd0);
         chk("rst_wb_valid", o_wb_valid, 64'd0);
         chk("rst_wb_wdata", o_wb_wdata, 64'd0);
         chk("rst_fwd_valid", o_fwd_valid, 64'd0);
         chk("rst_fwd_pending", o_fwd_pending, 64'd0);
         chk("rst_excp", o_excp, 64'd0);
      end
      rst = 1'b1;
      cyc();

      // back-to-back non-memory ops, one per cycle
      vals[0] = 64'h11; vals[1] = 64'h22; vals[2] = 64'h33;
      sel = 1'b0; wb_ready = 1'b1; ex_valid = 1'b1; ex_op = 4'd0; ex_rf_we = 1'b1; ex_rf_waddr = 5'd3;
      for (int i = 0; i < 3; i++) begin
         ex_result = vals[i];
         #1;
         chk("stream_ex_ready", o_ex_ready, 64'd1);
         if (i > 0) begin
            chk("stream_valid", o_wb_valid, 64'd1);
            chk("stream_wdata", o_wb_wdata, vals[i-1]);
         end
         cyc();
      end
      ex_valid = 1'b0;
      #1;
      chk("stream_valid", o_wb_valid, 64'd1);
      chk("stream_wdata", o_wb_wdata, vals[2]);
      cyc();
      #1;
      chk("stream_drained", o_wb_valid, 64'd0);

      // directed accesses
      run_one(1'b0, 4'd1,  64'h1003, 64'd0, 1'b1, 5'd1, 32'h40, 64'h80FF_0000, 0, 0, 0);
      run_one(1'b0, 4'd2,  64'h1003, 64'd0, 1'b1, 5'd2, 32'h44, 64'h80FF_0000, 0, 0, 0);
      run_one(1'b0, 4'd3,  64'h1002, 64'd0, 1'b1, 5'd3, 32'h48, 64'h80FF_0000, 0, 0, 0);
      run_one(1'b0, 4'd9,  64'h2002, 64'h1234_ABCD, 1'b0, 5'd0, 32'h4C, 64'd0, 0, 0, 0);
      run_one(1'b0, 4'd5,  64'h1001, 64'd0, 1'b1, 5'd4, 32'h50, 64'd0, 0, 0, 0);
      run_one(1'b0, 4'd5,  64'h1004, 64'd0, 1'b1, 5'd5, 32'h54, 64'hDEAD_BEEF, 3, 2, 2);
      run_one(1'b1, 4'd7,  64'h8, 64'd0, 1'b1, 5'd6, 32'h58, 64'h8000_0000_0000_0001, 0, 0, 0);
      run_one(1'b1, 4'd5,  64'h4, 64'd0, 1'b1, 5'd8, 32'h5C, 64'h8765_4321_0000_0000, 1, 1, 0);
      run_one(1'b1, 4'd11, 64'h10, 64'h0123_4567_89AB_CDEF, 1'b0, 5'd0, 32'h60, 64'd0, 0, 0, 0);

      // flush in RESP: drains through CANCEL, nothing reaches WB
      start_lw();
      dm_addr_ok = 1'b1;
      #1;
      chk("fr_req", o_dm_req, 64'd1);
      cyc();
      dm_addr_ok = 1'b0; flush = 1'b1;
      #1;
      chk("fr_pending", o_fwd_pending, 64'd1);
      chk("fr_ex_ready", o_ex_ready, 64'd0);
      cyc();
      flush = 1'b0;
      for (int i = 0; i < 4; i++) begin
         dm_data_ok = (i == 3);
         #1;
         chk("cancel_wb_valid", o_wb_valid, 64'd0);
         chk("cancel_ex_ready", o_ex_ready, 64'd0);
         chk("cancel_pending", o_fwd_pending, 64'd0);
         cyc();
      end
      dm_data_ok = 1'b0;
      #1;
      chk("cancel_done", o_ex_ready, 64'd1);
      chk("cancel_no_wb", o_wb_valid, 64'd0);

      // flush in REQ before acceptance -> straight to EMPTY
      start_lw();
      flush = 1'b1;
      #1;
      chk("fq_req", o_dm_req, 64'd1);
      cyc();
      flush = 1'b0;
      #1;
      chk("fq_empty", o_ex_ready, 64'd1);
      chk("fq_no_req", o_dm_req, 64'd0);

      // flush in REQ together with dm_addr_ok -> CANCEL
      start_lw();
      flush = 1'b1; dm_addr_ok = 1'b1;
      cyc();
      flush = 1'b0; dm_addr_ok = 1'b0; dm_data_ok = 1'b1;
      #1;
      chk("fqa_cancel", o_ex_ready, 64'd0);
      cyc();
      dm_data_ok = 1'b0;
      #1;
      chk("fqa_empty", o_ex_ready, 64'd1);
      chk("fqa_no_wb", o_wb_valid, 64'd0);

      // flush with dm_data_ok in RESP -> EMPTY, data discarded
      start_lw();
      dm_addr_ok = 1'b1;
      cyc();
      dm_addr_ok = 1'b0; flush = 1'b1; dm_data_ok = 1'b1;
      cyc();
      flush = 1'b0; dm_data_ok = 1'b0;
      #1;
      chk("frd_empty", o_ex_ready, 64'd1);
      chk("frd_no_wb", o_wb_valid, 64'd0);

      // flush in FULL while WB stalls
      sel = 1'b0; ex_valid = 1'b1; ex_op = 4'd0; ex_result = 64'h55; wb_ready = 1'b1;
      #1;
      cyc();
      ex_valid = 1'b0; wb_ready = 1'b0; flush = 1'b1;
      #1;
      chk("ff_valid", o_wb_valid, 64'd1);
      chk("ff_ex_ready", o_ex_ready, 64'd0);
      cyc();
      flush = 1'b0;
      #1;
      chk("ff_killed", o_wb_valid, 64'd0);

      // asynchronous reset while a request is outstanding
      start_lw();
      #1;
      chk("ar_req", o_dm_req, 64'd1);
      rst = 1'b0;
      #1;
      chk("ar_req_cleared", o_dm_req, 64'd0);
      chk("ar_pending_cleared", o_fwd_pending, 64'd0);
      chk("ar_ready", o_ex_ready, 64'd1);
      cyc();
      rst = 1'b1;
      cyc();

      // randomized instructions, wait states and WB back-pressure
      for (int n = 0; n < 150; n++) begin
         logic [63:0] ra, rsd, rrd;
         ra  = {32'd0, $urandom() & 32'hFFFF_FFF8} | 64'($urandom_range(0, 7));
         rsd = {$urandom(), $urandom()};
         rrd = {$urandom(), $urandom()};
         run_one(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), ra, rsd,
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom(), rrd,
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
